// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   scan_state_t : scan FSM state (IDLE, BLANK, SHOW)
//   SEG_OFF      : active-low segment pattern with every segment dark
//   ANODE_OFF    : all-ones anode vector; slice [NDIG-1:0] for NDIG <= ANODE_MAX
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int ANODE_MAX = 32;
    localparam logic [ANODE_MAX-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/decoder7.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_hex : 4-bit value to display
//   o_seg : active-low segment pattern, o_seg[0] = segment a
module decoder7 (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of NDIG common-anode 7-segment digits with guard blanking.
// Latency: first anode lights BLANK_CYC cycles after the edge that samples enable=1.
// Backpressure: in_ready low while a digit is lit (SHOW); loads land only in IDLE/BLANK.
//
// Optional build macro: LEAD_ZERO_BLANK_EN -- blank leading zero digits (digit 0 always shown).
//
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   enable         : 1 = scan, 0 = display dark (returns to IDLE next edge)
//   in_valid/ready : digit buffer load handshake
//   in_data        : NDIG hex digits, digit k = in_data[4k+3:4k], digit 0 rightmost
//   in_dp          : decimal points, active-high, bit k for digit k
//   seg, dp        : registered active-low segment bus and decimal point
//   an             : registered active-low anode enables (one-hot-low or all ones)
//   digit_idx      : index of the currently selected digit
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter  int NDIG      = 4,
    parameter  int DIV       = 50000,
    parameter  int BLANK_CYC = 2,
    localparam int IW        = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int CW        = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_data,
    input  logic [NDIG-1:0]   in_dp,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic [IW-1:0]     digit_idx
);

    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]   SHOW_LAST  = CW'(DIV - BLANK_CYC - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_OFF     = ANODE_OFF[NDIG-1:0];

    scan_state_t       r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [4*NDIG-1:0] r_buf;
    logic [NDIG-1:0]   r_dp_buf;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic [NDIG-1:0]   r_an;

    logic              w_load;
    logic [4*NDIG-1:0] w_buf_nxt;
    logic [NDIG-1:0]   w_dp_nxt;
    logic [3:0]        w_nib;
    logic              w_dp_sel;
    logic              w_lead_blank;
    logic [6:0]        w_dec_seg;

    // Ready is withheld in SHOW so the lit digit can never change under its anode.
    assign in_ready = ~reset & (r_state != SHOW);
    assign w_load   = in_valid & in_ready;

    // Decode from the post-load buffer so a load on the BLANK->SHOW edge is
    // what the upcoming SHOW displays.
    assign w_buf_nxt = w_load ? in_data : r_buf;
    assign w_dp_nxt  = w_load ? in_dp   : r_dp_buf;

    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib    = w_buf_nxt[4*k +: 4];
                w_dp_sel = w_dp_nxt[k];
            end
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    // Digit is a leading zero when it and every higher digit are zero.
    assign w_lead_blank = (r_idx != '0) && ((w_buf_nxt >> {r_idx, 2'b00}) == '0);
`else
    assign w_lead_blank = 1'b0;
`endif

    decoder7 u_decoder7 (
        .i_hex (w_nib),
        .o_seg (w_dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_buf    <= '0;
            r_dp_buf <= '0;
            r_seg    <= SEG_OFF;
            r_dp     <= 1'b1;
            r_an     <= AN_OFF;
        end else begin
            if (w_load) begin
                r_buf    <= in_data;
                r_dp_buf <= in_dp;
            end

            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_seg   <= SEG_OFF;
                r_dp    <= 1'b1;
                r_an    <= AN_OFF;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                    BLANK: begin
                        // Pattern is refreshed every guard cycle while anodes are off.
                        r_seg <= w_lead_blank ? SEG_OFF : w_dec_seg;
                        r_dp  <= ~w_dp_sel;
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= SHOW;
                            r_cnt   <= '0;
                            r_an    <= ~(NDIG'(1) << r_idx);
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    SHOW: begin
                        if (r_cnt == SHOW_LAST) begin
                            r_state <= BLANK;
                            r_cnt   <= '0;
                            r_an    <= AN_OFF;
                            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_an    <= AN_OFF;
                    end
                endcase
            end
        end
    end

    assign seg       = r_seg;
    assign dp        = r_dp;
    assign an        = r_an;
    assign digit_idx = r_idx;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment displays sharing one segment bus. Holds a digit buffer loaded through a valid/ready handshake and cycles through the digits one at a time. Drives a single `decoder7` instance with the selected nibble and enables the matching anode. Inserts guard (blank) cycles between digits to prevent ghosting. Sits between the system datapath and the board's display pins.

Parameters:
NDIG, 4, number of digits scanned (≥1)
DIV, 50000, clock cycles per digit slot, guard cycles included
BLANK_CYC, 2, guard cycles per slot with all anodes off; constraint 1 ≤ BLANK_CYC < DIV

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; 0 = display dark
in_valid  in  1  new buffer contents offered
in_ready  out  1  buffer can accept contents this cycle
in_data  in  4*NDIG  hex digits; digit k = in_data[4k+3:4k], digit 0 is rightmost
in_dp  in  NDIG  decimal points, active-high, bit k for digit k
seg  out  7  segment bus, active-low, registered
dp  out  1  decimal point, active-low, registered
an  out  NDIG  anode enables, active-low, one-hot-low or all-ones
digit_idx  out  $clog2(NDIG) (min 1)  index of the digit currently selected

Behaviour:
- One clock; reset is synchronous and active-high. clk and reset as named above.
- Reset values (the cycle after reset is sampled high):
  - state = IDLE; an = all 1s; seg = 7'h7F; dp = 1; digit_idx = 0.
  - Buffer = 0, dp buffer = 0; slot counter = 0; in_ready = 0 while reset is high.
- States:
  - IDLE: anodes off, seg = 7'h7F.
  - BLANK: anodes off; seg/dp loaded with the pattern of buffer[digit_idx] via `decoder7`.
  - SHOW: an[digit_idx] = 0, others 1; seg/dp held.
- Transitions:
  - IDLE→BLANK when enable = 1. Counter cleared; digit_idx = 0.
  - BLANK→SHOW after BLANK_CYC cycles.
  - SHOW→BLANK after DIV−BLANK_CYC cycles. digit_idx increments and wraps NDIG−1→0.
  - Any state→IDLE on the cycle after enable = 0. Anodes off, digit_idx = 0.
  - Slot counter width is $clog2(DIV); it is cleared on every state change.
- Handshake:
  - in_ready = 1 in IDLE and BLANK, 0 in SHOW.
  - The transfer occurs on in_valid & in_ready at the clock edge; buffer and dp buffer update at that edge.
  - The displayed digit therefore never changes while its anode is lit (glitch-free).
  - in_valid held through SHOW is accepted on the first BLANK cycle.
  - in_data/in_dp are don't-care when in_valid = 0.
- seg/dp are registered from the decoder output each BLANK cycle, so the pattern is stable ≥1 cycle before the anode turns on.
- A load in the same cycle as the BLANK→SHOW transition is shown in the upcoming SHOW.
- Full scan period = NDIG*DIV cycles; first anode asserts BLANK_CYC+1 cycles after enable rises.
- Reset mid-SHOW: reset takes priority over all transitions; outputs take reset values on the next edge.

Optional Feature:
Macro LEAD_ZERO_BLANK_EN.
- Defined: any digit k > 0 whose value is 0 and whose higher digits (k+1..NDIG−1) are all 0 shows seg = 7'h7F, with dp still honoured. The anode still turns on, so timing is unchanged. Digit 0 is always shown.
- Undefined: all digits are decoded normally.

Decomposition:
- Package `display_pkg`:
  - state enum typedef (IDLE, BLANK, SHOW);
  - SEG_OFF = 7'h7F;
  - ANODE_OFF helper localparam.
- Sub-modules:
  - Instantiate the existing `decoder7` once.
  - No other sub-module; the slot counter stays inline.

Test Plan:
All scenarios use NDIG=4, DIV=8, BLANK_CYC=2.
1. Reset: reset held 3 cycles with enable=1 → an=4'hF, seg=7'h7F, dp=1, in_ready=0. in_ready=1 the cycle after reset drops.
2. Basic scan: load 16'h1234, in_dp=4'b0000, enable=1.
   - Anodes cycle 1110 (seg 7'b0011001, '4'), 1101 (7'b0110000, '3'), 1011 (7'b0100100, '2'), 0111 (7'b1111001, '1').
   - Each anode is low 6 cycles, separated by 2 all-off cycles; the pattern repeats every 32 cycles.
3. Handshake stall: raise in_valid with 16'hABCD mid-SHOW → in_ready=0 until the next BLANK. Accepted there; the following digit shows the new value, and the old digit is never corrupted while lit.
4. Enable drop: deassert enable during SHOW of digit 2 → next cycle an=4'hF, seg=7'h7F. On re-enable, the scan restarts at digit 0.
5. Wrap/dp: in_dp=4'b1000, scan past digit 3 → dp=0 only while an=0111; digit_idx returns 3→0.
6. LEAD_ZERO_BLANK_EN: load 16'h0050 → digits 3 and 2 show 7'h7F, digit 1 shows '5' (7'b0010010), digit 0 shows '0' (7'b1000000). With the macro undefined, digits 3 and 2 show '0'.
